// File: rtl/reg_arb_pkg.sv
// Shared constants and helpers for the register write arbiter.
package reg_arb_pkg;

   // Completed-write counter width and its saturation value.
   localparam int          CNT_W   = 16;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // Widest bank the decoder supports.
   localparam int MAX_REGS = 16;
   localparam int MAX_AW   = 4;

   // One-hot decode of a register address. An address at or beyond
   // num_regs decodes to all zeros, so no bank register is touched.
   function automatic logic [MAX_REGS-1:0] onehot_dec(input logic [MAX_AW-1:0] addr,
                                                      input int unsigned       num_regs);
      logic [MAX_REGS-1:0] vec;
      vec = {MAX_REGS{1'b0}};
      if ({28'd0, addr} < num_regs) begin
         vec[addr] = 1'b1;
      end else begin
         vec = {MAX_REGS{1'b0}};
      end
      return vec;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// Round-robin grant logic: first valid requester at or after ptr wins.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NUM_REQ-1:0] valid,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     grant_idx,
   output logic               any_grant
);

   logic [IDW-1:0]     ptr_r;
   logic [NUM_REQ-1:0] grant_s;
   logic [IDW-1:0]     grant_idx_s;
   logic               any_grant_s;
   logic [IDW-1:0]     ptr_next_s;

   // Scan requesters starting at ptr, wrapping; gated by en and by reset.
   always_comb begin
      int j;
      j           = 0;
      grant_s     = {NUM_REQ{1'b0}};
      grant_idx_s = {IDW{1'b0}};
      any_grant_s = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr_r) + k) % NUM_REQ;
         if (rst_n && en && !any_grant_s && valid[j]) begin
            grant_s[j]  = 1'b1;
            grant_idx_s = IDW'(j);
            any_grant_s = 1'b1;
         end else begin
            any_grant_s = any_grant_s;
         end
      end
   end

   // Pointer moves just past the winner; NUM_REQ need not be a power of two.
   always_comb begin
      ptr_next_s = ptr_r;
      if (!any_grant_s) begin
         ptr_next_s = ptr_r;
      end else if (grant_idx_s == IDW'(NUM_REQ - 1)) begin
         ptr_next_s = {IDW{1'b0}};
      end else begin
         ptr_next_s = grant_idx_s + IDW'(1);
      end
   end

   // Priority pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= {IDW{1'b0}};
      end else begin
         ptr_r <= ptr_next_s;
      end
   end

   assign grant     = grant_s;
   assign grant_idx = grant_idx_s;
   assign any_grant = any_grant_s;

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares a bank of load-enabled registers among requesters: round-robin
// grant, registered one-hot load strobe, address error pulse and a
// saturating count of completed in-range writes.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int NUM_REQ  = 4,
   parameter  int NUM_REGS = 6,
   localparam int AW       = $clog2(NUM_REGS),
   localparam int IDW      = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*AW-1:0]    req_addr,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REGS-1:0]      reg_load,
   output logic [WIDTH-1:0]         reg_data,
   output logic [IDW-1:0]           grant_id,
   output logic                     addr_err,
   output logic [CNT_W-1:0]         wr_count
);

   logic [NUM_REQ-1:0]  grant_s;
   logic [IDW-1:0]      grant_idx_s;
   logic                any_grant_s;
   logic [AW-1:0]       sel_addr_s;
   logic [WIDTH-1:0]    sel_data_s;
   logic [MAX_REGS-1:0] dec_full_s;
   logic                in_range_s;

   logic [NUM_REGS-1:0] reg_load_r;
   logic [WIDTH-1:0]    reg_data_r;
   logic [IDW-1:0]      grant_id_r;
   logic                addr_err_r;
   logic [CNT_W-1:0]    wr_count_r;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .valid     (req_valid),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .any_grant (any_grant_s)
   );

   assign req_ready = grant_s;

   // Select the winning requester's address and data.
   always_comb begin
      sel_addr_s = {AW{1'b0}};
      sel_data_s = {WIDTH{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx_s == IDW'(i)) begin
            sel_addr_s = req_addr[i*AW +: AW];
            sel_data_s = req_data[i*WIDTH +: WIDTH];
         end else begin
            sel_addr_s = sel_addr_s;
         end
      end
   end

   assign dec_full_s = onehot_dec(MAX_AW'(sel_addr_s), NUM_REGS);
   assign in_range_s = |dec_full_s;

   // Output stage: one-cycle load or error pulse per transfer; data/id hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_load_r <= {NUM_REGS{1'b0}};
         reg_data_r <= {WIDTH{1'b0}};
         grant_id_r <= {IDW{1'b0}};
         addr_err_r <= 1'b0;
      end else if (any_grant_s) begin
         reg_load_r <= dec_full_s[NUM_REGS-1:0];
         reg_data_r <= sel_data_s;
         grant_id_r <= grant_idx_s;
         addr_err_r <= !in_range_s;
      end else begin
         reg_load_r <= {NUM_REGS{1'b0}};
         addr_err_r <= 1'b0;
      end
   end

   // Saturating count of completed in-range writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_count_r <= {CNT_W{1'b0}};
      end else if (any_grant_s && in_range_s && (wr_count_r != CNT_MAX)) begin
         wr_count_r <= wr_count_r + 16'd1;
      end else begin
         wr_count_r <= wr_count_r;
      end
   end

   assign reg_load = reg_load_r;
   assign reg_data = reg_data_r;
   assign grant_id = grant_id_r;
   assign addr_err = addr_err_r;
   assign wr_count = wr_count_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed, table-driven bench for reg_write_arbiter (WIDTH=8, NUM_REQ=4, NUM_REGS=6).
module tb_reg_write_arbiter;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [3:0]  req_valid;
   logic [11:0] req_addr;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [5:0]  reg_load;
   logic [7:0]  reg_data;
   logic [1:0]  grant_id;
   logic        addr_err;
   logic [15:0] wr_count;

   int checks;
   int failures;

   reg_write_arbiter #(.WIDTH(8), .NUM_REQ(4), .NUM_REGS(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .reg_load  (reg_load),
      .reg_data  (reg_data),
      .grant_id  (grant_id),
      .addr_err  (addr_err),
      .wr_count  (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [3:0]  valid;
      logic [11:0] addr;
      logic [31:0] data;
      logic [3:0]  rdy;
      logic [5:0]  load;
      logic        err;
      logic [1:0]  gid;
      logic [7:0]  rd;
      logic [15:0] cnt;
   } vec_t;

   localparam logic [11:0] A_DEF = 12'h688;       // req3..0 -> 3,2,1,0
   localparam logic [31:0] D_DEF = 32'h13121110;  // req3..0 -> 13,12,11,10

   vec_t tbl[23];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic e, input logic [3:0] v, input logic [11:0] a,
                               input logic [31:0] d, input logic [3:0] r, input logic [5:0] l,
                               input logic er, input logic [1:0] g, input logic [7:0] rd,
                               input logic [15:0] c);
      vec_t t;
      t.en = e; t.valid = v; t.addr = a; t.data = d; t.rdy = r;
      t.load = l; t.err = er; t.gid = g; t.rd = rd; t.cnt = c;
      return t;
   endfunction

   initial begin
      checks   = 0;
      failures = 0;

      // Rotation over all four requesters, two laps.
      for (int i = 0; i < 8; i++) begin
         tbl[i] = mk(1'b1, 4'hF, A_DEF, D_DEF, 4'(1 << (i % 4)), 6'(1 << (i % 4)),
                     1'b0, 2'(i % 4), 8'(8'h10 + (i % 4)), 16'(i + 1));
      end
      // Only requesters 1 and 3 (first vector moves ptr to 2).
      tbl[8]  = mk(1'b1, 4'b0010, A_DEF, D_DEF, 4'b0010, 6'b000010, 1'b0, 2'd1, 8'h11, 16'd9);
      tbl[9]  = mk(1'b1, 4'b1010, A_DEF, D_DEF, 4'b1000, 6'b001000, 1'b0, 2'd3, 8'h13, 16'd10);
      tbl[10] = mk(1'b1, 4'b1010, A_DEF, D_DEF, 4'b0010, 6'b000010, 1'b0, 2'd1, 8'h11, 16'd11);
      tbl[11] = mk(1'b1, 4'b1010, A_DEF, D_DEF, 4'b1000, 6'b001000, 1'b0, 2'd3, 8'h13, 16'd12);
      // Requester 2 writes out-of-range address 7.
      tbl[12] = mk(1'b1, 4'b0100, 12'h7C8, 32'h13AA1110, 4'b0100, 6'b000000, 1'b1, 2'd2, 8'hAA, 16'd12);
      // Idle: pulses drop, data/id hold.
      tbl[13] = mk(1'b1, 4'b0000, A_DEF, D_DEF, 4'b0000, 6'b000000, 1'b0, 2'd2, 8'hAA, 16'd12);
      // en low for five cycles with all valid.
      for (int i = 14; i < 19; i++) begin
         tbl[i] = mk(1'b0, 4'hF, A_DEF, D_DEF, 4'b0000, 6'b000000, 1'b0, 2'd2, 8'hAA, 16'd12);
      end
      // Resume at the pre-stall pointer (3).
      tbl[19] = mk(1'b1, 4'hF, A_DEF, D_DEF, 4'b1000, 6'b001000, 1'b0, 2'd3, 8'h13, 16'd13);
      // Requesters 0 and 1 both target register 5 back to back.
      tbl[20] = mk(1'b1, 4'b0011, 12'h6AD, 32'h13122221, 4'b0001, 6'b100000, 1'b0, 2'd0, 8'h21, 16'd14);
      tbl[21] = mk(1'b1, 4'b0011, 12'h6AD, 32'h13122221, 4'b0010, 6'b100000, 1'b0, 2'd1, 8'h22, 16'd15);
      // Address 6 == NUM_REGS is out of range; ptr wraps 2 -> 0.
      tbl[22] = mk(1'b1, 4'b0001, 12'h68E, 32'h1312115A, 4'b0001, 6'b000000, 1'b1, 2'd0, 8'h5A, 16'd15);

      // Reset with all requesters valid: no ready, outputs zero.
      rst_n     = 1'b0;
      en        = 1'b1;
      req_valid = 4'hF;
      req_addr  = A_DEF;
      req_data  = D_DEF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_load", 32'(reg_load), 32'h0);
      chk("rst_data", 32'(reg_data), 32'h0);
      chk("rst_gid", 32'(grant_id), 32'h0);
      chk("rst_err", 32'(addr_err), 32'h0);
      chk("rst_cnt", 32'(wr_count), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // That edge transferred req0; resynchronise with a fresh reset.
      rst_n = 1'b0;
      req_valid = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table: apply, check combinational ready, then the registered stage.
      for (int i = 0; i < 23; i++) begin
         en        = tbl[i].en;
         req_valid = tbl[i].valid;
         req_addr  = tbl[i].addr;
         req_data  = tbl[i].data;
         #1;
         chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_load", i), 32'(reg_load), 32'(tbl[i].load));
         chk($sformatf("v%0d_err", i), 32'(addr_err), 32'(tbl[i].err));
         chk($sformatf("v%0d_gid", i), 32'(grant_id), 32'(tbl[i].gid));
         chk($sformatf("v%0d_data", i), 32'(reg_data), 32'(tbl[i].rd));
         chk($sformatf("v%0d_cnt", i), 32'(wr_count), 32'(tbl[i].cnt));
      end

      // Reset asserted during a transfer cycle (ptr is 1 here).
      en        = 1'b1;
      req_valid = 4'hF;
      req_addr  = A_DEF;
      req_data  = D_DEF;
      #1;
      chk("mr_pre_ready", 32'(req_ready), 32'h2);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr_ready", 32'(req_ready), 32'h0);
      chk("mr_load", 32'(reg_load), 32'h0);
      chk("mr_data", 32'(reg_data), 32'h0);
      chk("mr_gid", 32'(grant_id), 32'h0);
      chk("mr_cnt", 32'(wr_count), 32'h0);
      @(posedge clk);
      #1;
      chk("mr_load_next", 32'(reg_load), 32'h0);
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 4'b1101;
      #1;
      chk("mr_after_ready", 32'(req_ready), 32'h1);
      chk("mr_after_err", 32'(addr_err), 32'h0);
      @(posedge clk);
      #1;
      chk("mr_after_load", 32'(reg_load), 32'h01);
      chk("mr_after_gid", 32'(grant_id), 32'h0);
      chk("mr_after_cnt", 32'(wr_count), 32'h1);

      // Saturation: continuous in-range writes from a count of 1.
      repeat (65533) @(posedge clk);
      #1;
      chk("sat_fffe", 32'(wr_count), 32'hFFFE);
      @(posedge clk);
      #1;
      chk("sat_ffff", 32'(wr_count), 32'hFFFF);
      repeat (3) @(posedge clk);
      #1;
      chk("sat_hold", 32'(wr_count), 32'hFFFF);
      chk("sat_load_active", 32'(|reg_load), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
